// File: rtl/datapath_pkg.sv
// datapath_pkg: shared definitions for the arbitrated A/B/ALU/R datapath controller.
//   - state codes (exposed on the estado debug port)
//   - ALU operation, R-register operation and ALU operand-select encodings
//   - opcode constants and per-opcode EXEC step count
//   - micro-code word layout produced by dp_ucode
package datapath_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoadA = 3'd1,
        StLoadB = 3'd2,
        StExec  = 3'd3,
        StDone  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        AluNone = 2'b00,
        AluAdd  = 2'b01,
        AluSub  = 2'b10
    } alu_op_e;

    typedef enum logic [1:0] {
        RegHold = 2'b00,
        RegLoad = 2'b01,
        RegShr  = 2'b10   // load R with the ALU result shifted right by one
    } reg_op_e;

    // ALU second operand select
    localparam logic SelB = 1'b0;
    localparam logic SelR = 1'b1;

    // Opcodes
    localparam logic [1:0] OpcDiff = 2'b00;  // A + (A - B)
    localparam logic [1:0] OpcAvg  = 2'b01;  // (A + (A + (A + B))) / 2
    localparam logic [1:0] OpcAdd  = 2'b10;  // A + B
    localparam logic [1:0] OpcSub  = 2'b11;  // A - B

    typedef struct packed {
        logic    sel;
        alu_op_e op;
        reg_op_e opreg;
        logic    last;
    } ucode_t;

    // Number of EXEC micro-steps for each opcode
    function automatic int unsigned step_count(input logic [1:0] opc);
        case (opc)
            OpcDiff: step_count = 2;
            OpcAvg:  step_count = 3;
            default: step_count = 1;
        endcase
    endfunction

endpackage

// File: rtl/dp_ucode.sv
// dp_ucode: combinational micro-code table for the EXEC phase.
// Ports:
//   opcode  in  2         latched opcode of the granted requester
//   k       in  N_STEP_W  current EXEC step
//   uc      out ucode_t   {Sel, Op, OpReg, last}; last flags the opcode's final step
// Steps beyond an opcode's length decode to all-zero controls.
module dp_ucode
    import datapath_pkg::*;
#(
    parameter int unsigned N_STEP_W = 2
) (
    input  logic [1:0]          opcode,
    input  logic [N_STEP_W-1:0] k,
    output ucode_t              uc
);

    always_comb begin
        uc = '{sel: SelB, op: AluNone, opreg: RegHold, last: 1'b0};
        case (opcode)
            OpcDiff: begin
                if (k == N_STEP_W'(0)) begin
                    uc.op    = AluSub;
                    uc.opreg = RegLoad;
                end else if (k == N_STEP_W'(1)) begin
                    uc.sel   = SelR;
                    uc.op    = AluAdd;
                    uc.opreg = RegLoad;
                end
            end
            OpcAvg: begin
                if (k == N_STEP_W'(0)) begin
                    uc.op    = AluAdd;
                    uc.opreg = RegLoad;
                end else if (k == N_STEP_W'(1)) begin
                    uc.sel   = SelR;
                    uc.op    = AluAdd;
                    uc.opreg = RegLoad;
                end else if (k == N_STEP_W'(2)) begin
                    uc.sel   = SelR;
                    uc.op    = AluAdd;
                    uc.opreg = RegShr;
                end
            end
            OpcAdd: begin
                if (k == N_STEP_W'(0)) begin
                    uc.op    = AluAdd;
                    uc.opreg = RegLoad;
                end
            end
            default: begin  // OpcSub
                if (k == N_STEP_W'(0)) begin
                    uc.op    = AluSub;
                    uc.opreg = RegLoad;
                end
            end
        endcase
        uc.last = ((32'(k) + 32'd1) == step_count(opcode));
    end

endmodule

// File: rtl/arbitro_datapath.sv
// arbitro_datapath: two-requester arbiter and micro-sequencer driving the shared
// A/B register, ALU and result-register datapath.
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-low reset
//   req[1:0]           request per requester
//   instr0, instr1     2-bit opcodes, sampled only when a grant is issued
//   gnt[1:0]           one-hot grant, held for the whole transaction
//   done[1:0]          one-cycle completion pulse to the granted requester
//   busy               high whenever not IDLE
//   EnA, EnB           A / B register load enables
//   Sel, Op, OpReg     ALU operand select, ALU op, R-register op
//   estado[2:0]        current state code (debug)
// Configuration: define ARB_FIXED_PRIO_EN to make requester 0 always win
// simultaneous requests; otherwise arbitration is round-robin.
module arbitro_datapath
    import datapath_pkg::*;
#(
    parameter int unsigned N_STEP_W = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] instr0,
    input  logic [1:0] instr1,
    output logic [1:0] gnt,
    output logic [1:0] done,
    output logic       busy,
    output logic       EnA,
    output logic       EnB,
    output logic       Sel,
    output logic [1:0] Op,
    output logic [1:0] OpReg,
    output logic [2:0] estado
);

    state_e              state_q, state_d;
    logic [N_STEP_W-1:0] k_q;
    logic [1:0]          opc_q;
    logic [1:0]          gnt_q;
    logic                win;      // index of the requester that wins in IDLE
    ucode_t              uc;

    dp_ucode #(
        .N_STEP_W (N_STEP_W)
    ) u_ucode (
        .opcode (opc_q),
        .k      (k_q),
        .uc     (uc)
    );

`ifdef ARB_FIXED_PRIO_EN
    assign win = ~req[0];
`else
    logic last_q;  // requester served most recently; resets to 1 so requester 0 wins first

    assign win = (req == 2'b11) ? ~last_q : req[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= 1'b1;
        end else if (state_q == StIdle && |req) begin
            last_q <= win;
        end
    end
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Transaction context: grant, opcode and step counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt_q <= 2'b00;
            opc_q <= 2'b00;
            k_q   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (|req) begin
                        gnt_q <= win ? 2'b10 : 2'b01;
                        opc_q <= win ? instr1 : instr0;
                    end
                end
                StLoadB: k_q <= '0;
                StExec:  k_q <= k_q + 1'b1;
                StDone: begin
                    gnt_q <= 2'b00;
                    k_q   <= '0;
                end
                default: ;
            endcase
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (|req) state_d = StLoadA;
            StLoadA: state_d = StLoadB;
            StLoadB: state_d = StExec;
            StExec:  if (uc.last) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Moore outputs
    always_comb begin
        EnA   = 1'b0;
        EnB   = 1'b0;
        Sel   = 1'b0;
        Op    = 2'b00;
        OpReg = 2'b00;
        done  = 2'b00;
        case (state_q)
            StLoadA: EnA = 1'b1;
            StLoadB: EnB = 1'b1;
            StExec: begin
                Sel   = uc.sel;
                Op    = uc.op;
                OpReg = uc.opreg;
            end
            StDone:  done = gnt_q;
            default: ;
        endcase
    end

    assign gnt    = gnt_q;
    assign busy   = (state_q != StIdle);
    assign estado = state_q;

endmodule
